seven_seg_scan: RTL

Parametrised multiplexed seven-segment driver for the board display. It is the next generation of the fixed four-letter banner driver. It scans `DIGITS` common-anode digits and decodes a 5-bit character code per digit (hex plus letters). Frames are double-buffered so a new message never tears mid-scan, and it adds decimal points, a global blank and an on-chip refresh prescaler. It sits between the maze-solver status logic, which supplies characters, and the board's `seg`/`dp`/`an` pins.

---
 rtl/seven_seg_scan_if.sv | 30 +++
 rtl/seven_seg_scan.sv | 136 +++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_if
// Description : Character-load and display-pin bundle for seven_seg_scan.
//               master = status logic / bench, slave = display driver.
// Revision    : 1.0 - initial release
// ============================================================================
interface seven_seg_scan_if #(
   parameter int DIGITS = 4
);
   logic                  load;
   logic [5*DIGITS-1:0]   chars;
   logic [DIGITS-1:0]     dps;
   logic                  en;
   logic [6:0]            seg;
   logic                  dp;
   logic [DIGITS-1:0]     an;
   logic                  frame_done;

   modport master (
      output load, chars, dps, en,
      input  seg, dp, an, frame_done
   );

   modport slave (
      input  load, chars, dps, en,
      output seg, dp, an, frame_done
   );
endinterface
`default_nettype wire

// File: rtl/seven_seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan
// Description : Multiplexed common-anode seven-segment driver. Scans DIGITS
//               digits (leftmost first) with a DIV-cycle prescaler, decodes
//               5-bit character codes and double-buffers each frame so a new
//               message only takes effect at a frame boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan #(
   parameter int DIGITS = 4,
   parameter int DIV    = 1
) (
   input  logic            segclk,
   input  logic            clr,
   seven_seg_scan_if.slave bus
);

   localparam int c_cw = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int c_iw = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [c_cw-1:0] c_cnt_last = c_cw'(DIV - 1);
   localparam logic [c_iw-1:0] c_idx_last = c_iw'(DIGITS - 1);
   localparam logic [4:0]      c_blank    = 5'd31;

   logic [c_cw-1:0]       r_cnt;
   logic [c_iw-1:0]       r_idx;
   logic                  r_pend;
   logic [5*DIGITS-1:0]   r_pend_chars;
   logic [DIGITS-1:0]     r_pend_dps;
   logic [5*DIGITS-1:0]   r_act_chars;
   logic [DIGITS-1:0]     r_act_dps;
   logic [6:0]            r_seg;
   logic                  r_dp;
   logic [DIGITS-1:0]     r_an;
   logic                  r_frame_done;

   logic                  w_step;
   logic                  w_frame;
   logic [4:0]            w_code;
   logic                  w_dp_lit;
   logic [DIGITS-1:0]     w_an_sel;

   // Character code to active-low {g,f,e,d,c,b,a}
   function automatic logic [6:0] f_decode(input logic [4:0] code);
      logic [6:0] pat;
      case (code)
         5'd0:    pat = 7'b1000000;
         5'd1:    pat = 7'b1111001;
         5'd2:    pat = 7'b0100100;
         5'd3:    pat = 7'b0110000;
         5'd4:    pat = 7'b0011001;
         5'd5:    pat = 7'b0010010;
         5'd6:    pat = 7'b0000010;
         5'd7:    pat = 7'b1111000;
         5'd8:    pat = 7'b0000000;
         5'd9:    pat = 7'b0010000;
         5'd10:   pat = 7'b0001000;
         5'd11:   pat = 7'b0000011;
         5'd12:   pat = 7'b1000110;
         5'd13:   pat = 7'b0100001;
         5'd14:   pat = 7'b0000110;
         5'd15:   pat = 7'b0001110;
         5'd16:   pat = 7'b1001000;
         5'd17:   pat = 7'b1001100;
         5'd18:   pat = 7'b0001100;
         5'd19:   pat = 7'b0111111;
         default: pat = 7'b1111111;
      endcase
      return pat;
   endfunction

   assign w_step   = (r_cnt == c_cnt_last);
   assign w_frame  = w_step && (r_idx == '0);
   assign w_code   = r_act_chars[int'(r_idx)*5 +: 5];
   assign w_dp_lit = r_act_dps[r_idx];
   assign w_an_sel = ~(DIGITS'(1) << r_idx);

   // Pending message data; contents are meaningless until pend is set
   always_ff @(posedge segclk) begin
      if (bus.load) begin
         r_pend_chars <= bus.chars;
         r_pend_dps   <= bus.dps;
      end
   end

   // Prescaler, digit scan, frame buffer swap and registered pin drive
   always_ff @(posedge segclk or posedge clr) begin
      if (clr) begin
         r_cnt        <= '0;
         r_idx        <= c_idx_last;
         r_pend       <= 1'b0;
         r_act_chars  <= {DIGITS{c_blank}};
         r_act_dps    <= '0;
         r_seg        <= 7'b1111111;
         r_dp         <= 1'b1;
         r_an         <= '1;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_frame;

         // A load on the boundary edge lands in pending after the old
         // pending contents have moved to active, so pend stays set.
         if (bus.load) begin
            r_pend <= 1'b1;
         end else if (w_frame) begin
            r_pend <= 1'b0;
         end

         if (w_frame && r_pend) begin
            r_act_chars <= r_pend_chars;
            r_act_dps   <= r_pend_dps;
         end

         if (w_step) begin
            r_cnt <= '0;
            r_seg <= f_decode(w_code);
            r_dp  <= ~w_dp_lit;
            r_an  <= bus.en ? w_an_sel : '1;
            if (r_idx == '0) begin
               r_idx <= c_idx_last;
            end else begin
               r_idx <= r_idx - 1'b1;
            end
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign bus.seg        = r_seg;
   assign bus.dp         = r_dp;
   assign bus.an         = r_an;
   assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire
